// File: rtl/ds_pkg.sv
// ds_pkg: shared defaults and forwarding-stage indices for the decode-stage issue controller.
package ds_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_AW = 5;
  localparam logic [31:0] DEF_RESET_PC = 32'h1bfffffc;
  localparam int FWD_EX = 0;
  localparam int FWD_MS = 1;
  localparam int FWD_WS = 2;
endpackage

// File: rtl/ds_issue_ctrl_fwd_mux.sv
// ds_fwd_mux: resolves one source operand through a youngest-first forwarding network.
module ds_fwd_mux #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int NFWD = 3
) (
  input  logic [AW-1:0]        src_addr_i,
  input  logic [XLEN-1:0]      rf_rdata_i,
  input  logic [NFWD-1:0]      fwd_we_i,
  input  logic [NFWD*AW-1:0]   fwd_waddr_i,
  input  logic [NFWD*XLEN-1:0] fwd_wdata_i,
  input  logic [NFWD-1:0]      fwd_rdy_i,
  output logic [XLEN-1:0]      value_o,
  output logic                 not_ready_o
);
  // Scan oldest to youngest so the youngest hit overwrites any older one.
  always_comb begin
    value_o = rf_rdata_i;
    not_ready_o = 1'b0;
    for (int j = NFWD - 1; j >= 0; j--) begin
      if (fwd_we_i[j] && src_addr_i != '0 && fwd_waddr_i[j*AW +: AW] == src_addr_i) begin
        value_o = fwd_wdata_i[j*XLEN +: XLEN];
        not_ready_o = !fwd_rdy_i[j];
      end
    end
  end
endmodule

// File: rtl/ds_issue_ctrl.sv
// ds_issue_ctrl: IF/ID register, issue handshake, operand forwarding and hazard-stall accounting.
module ds_issue_ctrl
  import ds_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW = DEF_AW,
  parameter int NSRC = 2,
  parameter int NFWD = 3,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int SCNT_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 fs_to_ds_valid,
  input  logic [31:0]          fs_inst,
  input  logic [XLEN-1:0]      fs_pc,
  output logic                 ds_allowin,
  input  logic                 es_allowin,
  output logic                 ds_to_es_valid,
  output logic                 ds_valid,
  output logic [31:0]          ds_inst,
  output logic [XLEN-1:0]      ds_pc,
  input  logic                 flush,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC-1:0]      src_need,
  input  logic [NSRC*XLEN-1:0] rf_rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_rdy,
  output logic [NSRC*XLEN-1:0] src_value,
  output logic                 stall,
  output logic [SCNT_W-1:0]    stall_cnt
);
  logic ds_valid_q, ds_valid_d;
  logic [31:0] ds_inst_q, ds_inst_d;
  logic [XLEN-1:0] ds_pc_q, ds_pc_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0] src_nrdy;
  logic load;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    ds_fwd_mux #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_mux (
      .src_addr_i  (src_addr[i*AW +: AW]),
      .rf_rdata_i  (rf_rdata[i*XLEN +: XLEN]),
      .fwd_we_i    (fwd_we),
      .fwd_waddr_i (fwd_waddr),
      .fwd_wdata_i (fwd_wdata),
      .fwd_rdy_i   (fwd_rdy),
      .value_o     (src_value[i*XLEN +: XLEN]),
      .not_ready_o (src_nrdy[i])
    );
  end
  assign stall = ds_valid_q & |(src_need & src_nrdy);
  assign ds_allowin = !ds_valid_q | (!stall & es_allowin);
  assign ds_to_es_valid = ds_valid_q & !stall;
  assign ds_valid = ds_valid_q;
  assign ds_inst = ds_inst_q;
  assign ds_pc = ds_pc_q;
  assign stall_cnt = stall_cnt_q;
  assign load = ds_allowin & fs_to_ds_valid;
  // Payload may load during a flush; it is dead because valid drops.
  always_comb begin
    ds_valid_d = flush ? 1'b0 : ds_allowin ? fs_to_ds_valid : ds_valid_q;
    ds_inst_d = load ? fs_inst : ds_inst_q;
    ds_pc_d = load ? fs_pc : ds_pc_q;
    stall_cnt_d = (stall & !flush & ~&stall_cnt_q) ? stall_cnt_q + SCNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_q <= 1'b0;
      ds_inst_q <= '0;
      ds_pc_q <= RESET_PC;
      stall_cnt_q <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_inst_q <= ds_inst_d;
      ds_pc_q <= ds_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_ds_issue_ctrl.sv
// tb_ds_issue_ctrl: directed plus randomized check of ds_issue_ctrl against a behavioural model.
module tb_ds_issue_ctrl;
  import ds_pkg::*;
  localparam int XLEN = 32, AW = 5, NSRC = 2, NFWD = 3;
  logic clk = 1'b0, resetn = 1'b0;
  logic fs_to_ds_valid = 1'b0, es_allowin = 1'b1, flush = 1'b0;
  logic [31:0] fs_inst = '0;
  logic [XLEN-1:0] fs_pc = '0;
  logic [NSRC*AW-1:0] src_addr = '0;
  logic [NSRC-1:0] src_need = '0;
  logic [NSRC*XLEN-1:0] rf_rdata = '0;
  logic [NFWD-1:0] fwd_we = '0, fwd_rdy = '1;
  logic [NFWD*AW-1:0] fwd_waddr = '0;
  logic [NFWD*XLEN-1:0] fwd_wdata = '0;
  logic ds_allowin, ds_to_es_valid, ds_valid, stall;
  logic [31:0] ds_inst;
  logic [XLEN-1:0] ds_pc;
  logic [NSRC*XLEN-1:0] src_value;
  logic [31:0] stall_cnt;
  logic s_allowin, s_to_es, s_valid, s_stall;
  logic [31:0] s_inst;
  logic [XLEN-1:0] s_pc;
  logic [NSRC*XLEN-1:0] s_value;
  logic [3:0] stall_cnt4;
  int tests = 0, fails = 0;
  logic m_valid = 1'b0;
  logic [31:0] m_inst = '0, m_pc = DEF_RESET_PC, m_cnt = '0;
  logic [3:0] m_cnt4 = '0;

  always #5 clk = ~clk;

  ds_issue_ctrl u_dut (
    .clk(clk), .resetn(resetn), .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
    .ds_valid(ds_valid), .ds_inst(ds_inst), .ds_pc(ds_pc), .flush(flush), .src_addr(src_addr),
    .src_need(src_need), .rf_rdata(rf_rdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy), .src_value(src_value), .stall(stall),
    .stall_cnt(stall_cnt)
  );

  ds_issue_ctrl #(.SCNT_W(4)) u_sat (
    .clk(clk), .resetn(resetn), .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
    .ds_allowin(s_allowin), .es_allowin(es_allowin), .ds_to_es_valid(s_to_es),
    .ds_valid(s_valid), .ds_inst(s_inst), .ds_pc(s_pc), .flush(flush), .src_addr(src_addr),
    .src_need(src_need), .rf_rdata(rf_rdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy), .src_value(s_value), .stall(s_stall),
    .stall_cnt(stall_cnt4)
  );

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // First producer, youngest first, writing register a; -1 when none.
  function automatic int first_hit(logic [AW-1:0] a);
    if (a == 0) return -1;
    for (int j = 0; j < NFWD; j++)
      if (fwd_we[j] && fwd_waddr[j*AW +: AW] == a) return j;
    return -1;
  endfunction

  function automatic void model_comb(output logic [NSRC*XLEN-1:0] sv, output logic st);
    st = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      int h;
      h = first_hit(src_addr[i*AW +: AW]);
      sv[i*XLEN +: XLEN] = (h < 0) ? rf_rdata[i*XLEN +: XLEN] : fwd_wdata[h*XLEN +: XLEN];
      if (h >= 0 && src_need[i] && !fwd_rdy[h]) st = 1'b1;
    end
    st = st & m_valid;
  endfunction

  always @(posedge clk or negedge resetn) begin
    logic [NSRC*XLEN-1:0] sv;
    logic st, ai;
    if (!resetn) begin
      m_valid <= 1'b0;
      m_inst <= '0;
      m_pc <= DEF_RESET_PC;
      m_cnt <= '0;
      m_cnt4 <= '0;
    end else begin
      model_comb(sv, st);
      ai = !m_valid || (!st && es_allowin);
      if (st && !flush && m_cnt != 32'hffffffff) m_cnt <= m_cnt + 1;
      if (st && !flush && m_cnt4 != 4'd15) m_cnt4 <= m_cnt4 + 1;
      if (ai && fs_to_ds_valid) begin
        m_inst <= fs_inst;
        m_pc <= fs_pc;
      end
      m_valid <= flush ? 1'b0 : ai ? fs_to_ds_valid : m_valid;
    end
  end

  always @(negedge clk) begin
    logic [NSRC*XLEN-1:0] sv;
    logic st;
    model_comb(sv, st);
    chk("ds_valid", ds_valid, m_valid);
    chk("ds_inst", ds_inst, m_inst);
    chk("ds_pc", ds_pc, m_pc);
    chk("stall", stall, st);
    chk("ds_allowin", ds_allowin, !m_valid || (!st && es_allowin));
    chk("ds_to_es_valid", ds_to_es_valid, m_valid && !st);
    chk("src_value", src_value, sv);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("stall_cnt4", stall_cnt4, m_cnt4);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("reset_pc", ds_pc, 32'h1bfffffc);
    chk("reset_valid", ds_valid, 0);
    chk("reset_allowin", ds_allowin, 1);
    chk("reset_cnt", stall_cnt, 0);
    resetn = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_pc = 32'h1c000000;
    fs_inst = 32'h02800c21;
    step();
    chk("stream_valid", ds_valid, 1);
    chk("stream_pc", ds_pc, 32'h1c000000);
    chk("stream_inst", ds_inst, 32'h02800c21);
    chk("stream_issue", ds_to_es_valid, 1);
    chk("stream_stall", stall, 0);
    src_addr[0 +: AW] = 5'd5;
    src_need = 2'b01;
    fwd_we = 3'b101;
    fwd_waddr[FWD_EX*AW +: AW] = 5'd5;
    fwd_waddr[FWD_WS*AW +: AW] = 5'd5;
    fwd_wdata[FWD_EX*XLEN +: XLEN] = 32'hAAAA;
    fwd_wdata[FWD_WS*XLEN +: XLEN] = 32'hBBBB;
    fwd_rdy = 3'b111;
    #1;
    chk("prio_ex", src_value[0 +: XLEN], 32'hAAAA);
    chk("prio_stall", stall, 0);
    fwd_we = 3'b100;
    #1;
    chk("prio_wb", src_value[0 +: XLEN], 32'hBBBB);
    step();
    fwd_we = 3'b001;
    fwd_waddr[FWD_EX*AW +: AW] = 5'd7;
    fwd_wdata[FWD_EX*XLEN +: XLEN] = 32'h1234;
    fwd_rdy = 3'b110;
    src_addr[AW +: AW] = 5'd7;
    src_need = 2'b10;
    #1;
    chk("lu_cnt0", stall_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      chk("lu_stall", stall, 1);
      chk("lu_allowin", ds_allowin, 0);
      chk("lu_issue", ds_to_es_valid, 0);
      step();
      chk("lu_cnt", stall_cnt, k);
    end
    fwd_rdy = 3'b111;
    #1;
    chk("lu_release", stall, 0);
    chk("lu_issue1", ds_to_es_valid, 1);
    chk("lu_value", src_value[XLEN +: XLEN], 32'h1234);
    step();
    src_addr = '0;
    src_need = 2'b11;
    fwd_we = 3'b001;
    fwd_waddr = '0;
    fwd_rdy = 3'b110;
    rf_rdata = {32'h22222222, 32'h11111111};
    #1;
    chk("r0_stall", stall, 0);
    chk("r0_value", src_value, {32'h22222222, 32'h11111111});
    step();
    src_addr[AW +: AW] = 5'd7;
    fwd_waddr[FWD_EX*AW +: AW] = 5'd7;
    step();
    chk("fl_stall_pre", stall, 1);
    chk("fl_cnt_pre", stall_cnt, 4);
    flush = 1'b1;
    step();
    chk("fl_valid", ds_valid, 0);
    chk("fl_stall", stall, 0);
    chk("fl_cnt", stall_cnt, 4);
    fs_pc = 32'h1c000010;
    step();
    chk("flv_valid", ds_valid, 0);
    chk("flv_pc", ds_pc, 32'h1c000010);
    flush = 1'b0;
    step();
    for (int k = 0; k < 20; k++) step();
    chk("sat_cnt4", stall_cnt4, 15);
    chk("sat_cnt", stall_cnt, 24);
    #2 resetn = 1'b0;
    #1;
    chk("ar_cnt", stall_cnt, 0);
    chk("ar_cnt4", stall_cnt4, 0);
    chk("ar_valid", ds_valid, 0);
    chk("ar_stall", stall, 0);
    step();
    resetn = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      fs_to_ds_valid = $urandom_range(0, 3) != 0;
      fs_inst = $urandom;
      fs_pc = $urandom;
      es_allowin = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      for (int i = 0; i < NSRC; i++) begin
        src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        rf_rdata[i*XLEN +: XLEN] = $urandom;
      end
      src_need = NSRC'($urandom);
      for (int j = 0; j < NFWD; j++) begin
        fwd_waddr[j*AW +: AW] = AW'($urandom_range(0, 7));
        fwd_wdata[j*XLEN +: XLEN] = $urandom;
        fwd_rdy[j] = $urandom_range(0, 2) != 0;
      end
      fwd_we = NFWD'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 resetn = 1'b0;
        #1 resetn = 1'b1;
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
